// File: rtl/reg_pkg.sv
// Shared definitions for the byte register and its serial readout.
package reg_pkg;

    localparam int unsigned REG_WIDTH = 8;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StShift = 2'd1,
        StPar   = 2'd2
    } state_e;

endpackage

// File: rtl/reg_shift_out.sv
// Parallel-to-serial readout: LSB-first over a valid/ready link, one holding buffer for
// back-to-back words. Define REG_SHIFT_OUT_PARITY_EN to append an even-parity beat per word.
module reg_shift_out
    import reg_pkg::*;
#(
    parameter int unsigned WIDTH = REG_WIDTH,
    parameter int unsigned CNT_W = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] data_in,
    input  logic             load,
    output logic             full,
    output logic             ser_out,
    output logic             ser_valid,
    input  logic             ser_ready,
    output logic             busy,
    output logic             done,
    output logic             overrun
);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] shreg_q, shreg_d;
    logic [WIDTH-1:0] buf_q, buf_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             full_q, full_d;
    logic             valid_q, valid_d;
    logic             overrun_q, overrun_d;
`ifdef REG_SHIFT_OUT_PARITY_EN
    logic             par_q, par_d;
`endif

    logic beat;
    logic accept;
    logic last_data;
    logic word_end;

    assign beat      = valid_q & ser_ready;
    assign accept    = load & ~full_q;
    assign last_data = (state_q == StShift) && (cnt_q == CNT_W'(WIDTH - 1));
`ifdef REG_SHIFT_OUT_PARITY_EN
    assign word_end  = beat & (state_q == StPar);
`else
    assign word_end  = beat & last_data;
`endif

    always_comb begin
        state_d   = state_q;
        shreg_d   = shreg_q;
        buf_d     = buf_q;
        cnt_d     = cnt_q;
        full_d    = full_q;
        valid_d   = valid_q;
        overrun_d = overrun_q | (load & full_q);
`ifdef REG_SHIFT_OUT_PARITY_EN
        par_d     = par_q;
`endif

        // A word arriving on the final beat bypasses the buffer and goes straight to the shifter.
        if (accept && (state_q != StIdle) && !word_end) begin
            buf_d  = data_in;
            full_d = 1'b1;
        end

        case (state_q)
            StIdle: begin
                if (accept) begin
                    shreg_d = data_in;
                    cnt_d   = '0;
                    valid_d = 1'b1;
                    state_d = StShift;
`ifdef REG_SHIFT_OUT_PARITY_EN
                    par_d   = ^data_in;
`endif
                end
            end
            StShift: begin
                if (beat && !last_data) begin
                    shreg_d = shreg_q >> 1;
                    cnt_d   = cnt_q + CNT_W'(1);
                end
`ifdef REG_SHIFT_OUT_PARITY_EN
                else if (beat) begin
                    state_d = StPar;
                    shreg_d = {{(WIDTH - 1){1'b0}}, par_q};
                end
`endif
            end
            StPar: begin
            end
            default: state_d = StIdle;
        endcase

        if (word_end) begin
            cnt_d = '0;
            if (full_q) begin
                shreg_d = buf_q;
                full_d  = 1'b0;
                state_d = StShift;
`ifdef REG_SHIFT_OUT_PARITY_EN
                par_d   = ^buf_q;
`endif
            end else if (accept) begin
                shreg_d = data_in;
                state_d = StShift;
`ifdef REG_SHIFT_OUT_PARITY_EN
                par_d   = ^data_in;
`endif
            end else begin
                shreg_d = '0;
                valid_d = 1'b0;
                state_d = StIdle;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q   <= StIdle;
            shreg_q   <= '0;
            buf_q     <= '0;
            cnt_q     <= '0;
            full_q    <= 1'b0;
            valid_q   <= 1'b0;
            overrun_q <= 1'b0;
`ifdef REG_SHIFT_OUT_PARITY_EN
            par_q     <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            shreg_q   <= shreg_d;
            buf_q     <= buf_d;
            cnt_q     <= cnt_d;
            full_q    <= full_d;
            valid_q   <= valid_d;
            overrun_q <= overrun_d;
`ifdef REG_SHIFT_OUT_PARITY_EN
            par_q     <= par_d;
`endif
        end
    end

    assign full      = full_q;
    assign ser_out   = shreg_q[0];
    assign ser_valid = valid_q;
    assign busy      = (state_q != StIdle) | full_q;
    // done coincides with the accepting beat; a reset in that cycle suppresses it
    assign done      = word_end & reset;
    assign overrun   = overrun_q;

endmodule

// File: tb/tb_reg_shift_out.sv
// Self-checking bench for reg_shift_out: directed sequences plus random traffic against a
// word-queue reference model. Honours REG_SHIFT_OUT_PARITY_EN when defined.
module tb_reg_shift_out;

    localparam int unsigned W = 8;

    logic         clk = 1'b0;
    logic         reset;
    logic [W-1:0] data_in;
    logic         load;
    logic         full;
    logic         ser_out;
    logic         ser_valid;
    logic         ser_ready;
    logic         busy;
    logic         done;
    logic         overrun;

    reg_shift_out #(
        .WIDTH(W)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .data_in  (data_in),
        .load     (load),
        .full     (full),
        .ser_out  (ser_out),
        .ser_valid(ser_valid),
        .ser_ready(ser_ready),
        .busy     (busy),
        .done     (done),
        .overrun  (overrun)
    );

    always #5 clk = ~clk;

    // Reference model: outstanding serial bits, word-end markers, count of unfinished words.
    bit q_bits[$];
    bit q_last[$];
    int words;
    bit ovr;

    int n_total = 0;
    int n_pass  = 0;

    task automatic chk(input string tag, input logic obs, input logic exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    endtask

    task automatic model_clear();
        q_bits.delete();
        q_last.delete();
        words = 0;
        ovr   = 1'b0;
    endtask

    task automatic model_push(input logic [W-1:0] d);
        for (int i = 0; i < W; i++) begin
            q_bits.push_back(d[i]);
`ifdef REG_SHIFT_OUT_PARITY_EN
            q_last.push_back(1'b0);
`else
            q_last.push_back(i == W - 1);
`endif
        end
`ifdef REG_SHIFT_OUT_PARITY_EN
        q_bits.push_back(^d);
        q_last.push_back(1'b1);
`endif
        words++;
    endtask

    // One clock cycle: drive, check at the falling edge, then advance the model.
    task automatic step(input bit rst_n, input bit ld, input logic [W-1:0] d, input bit rdy);
        bit exp_valid;
        bit exp_beat;
        bit exp_done;
        bit acc;
        bit lst;
        bit b;
        reset     = rst_n;
        load      = ld;
        data_in   = d;
        ser_ready = rdy;
        @(negedge clk);
        exp_valid = (words > 0);
        exp_beat  = exp_valid & rdy;
        exp_done  = rst_n & exp_beat & q_last[0];
        chk("done", done, exp_done);
        if (rst_n) begin
            chk("ser_valid", ser_valid, exp_valid);
            chk("full", full, words == 2);
            chk("busy", busy, words > 0);
            chk("overrun", overrun, ovr);
            if (exp_valid) chk("ser_out", ser_out, q_bits[0]);
        end
        if (!rst_n) begin
            model_clear();
        end else begin
            acc = ld & (words < 2);
            if (ld && words == 2) ovr = 1'b1;
            if (exp_beat) begin
                b   = q_bits.pop_front();
                lst = q_last.pop_front();
                if (lst) words--;
            end
            if (acc) model_push(d);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n, input bit rdy);
        for (int i = 0; i < n; i++) step(1'b1, 1'b0, '0, rdy);
    endtask

    initial begin
        model_clear();
        reset     = 1'b0;
        load      = 1'b0;
        data_in   = '0;
        ser_ready = 1'b0;
        @(posedge clk);
        #1;

        // Reset held two cycles with load asserted: load must be ignored.
        step(1'b0, 1'b1, 8'hFF, 1'b1);
        step(1'b0, 1'b1, 8'hFF, 1'b1);
        step(1'b1, 1'b0, '0, 1'b1);
        chk("ser_out_after_reset", ser_out, 1'b0);

        // Single word, consumer always ready.
        step(1'b1, 1'b1, 8'hA5, 1'b1);
        idle(W + 3, 1'b1);

        // Back-to-back words with no idle beat between them.
        step(1'b1, 1'b1, 8'h3C, 1'b1);
        step(1'b1, 1'b1, 8'hC3, 1'b1);
        idle(2 * W + 4, 1'b1);

        // Consumer accepts every other cycle.
        step(1'b1, 1'b1, 8'h81, 1'b0);
        for (int i = 0; i < 2 * W + 6; i++) step(1'b1, 1'b0, '0, i[0] == 1'b0);

        // Three loads in a row: third arrives while full and is dropped.
        step(1'b1, 1'b1, 8'h01, 1'b1);
        step(1'b1, 1'b1, 8'h02, 1'b1);
        step(1'b1, 1'b1, 8'h03, 1'b1);
        idle(2 * W + 6, 1'b1);

        // Parity-sensitive word, then reset in the middle of a word.
        step(1'b0, 1'b0, '0, 1'b1);
        step(1'b1, 1'b1, 8'h07, 1'b1);
        idle(W + 4, 1'b1);
        step(1'b1, 1'b1, 8'h5A, 1'b1);
        idle(3, 1'b1);
        step(1'b0, 1'b0, '0, 1'b1);
        idle(3, 1'b1);

        // Random traffic with an occasional reset.
        for (int i = 0; i < 600; i++) begin
            step(($urandom_range(0, 99) != 0), ($urandom_range(0, 2) == 0),
                 W'($urandom), ($urandom_range(0, 3) != 0));
        end

        // Reset landing exactly on a word's final beat must not produce done.
        step(1'b0, 1'b0, '0, 1'b1);
        step(1'b1, 1'b1, 8'hE1, 1'b1);
`ifdef REG_SHIFT_OUT_PARITY_EN
        idle(W, 1'b1);
`else
        idle(W - 1, 1'b1);
`endif
        step(1'b0, 1'b0, '0, 1'b1);
        idle(3, 1'b1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
